instr_fetch_queue: RTL and testbench

//  Producer side of the instruction-queue -> decoder interface.
//  - Fetches 32-bit instructions sequentially from the memory controller.
//  - Buffers them with their PCs in a FIFO.
//  - Presents the FIFO head to the decoder via decode_enable/instr.
//  - On update_stat (branch redirect or flush), empties the FIFO, drops any in-flight fetch and restarts at new_pc.

---
 rtl/instr_fetch_queue_pkg.sv | 22 ++
 rtl/instr_fetch_queue_if.sv | 26 ++
 rtl/instr_fetch_queue_sync_fifo.sv | 68 ++++++
 rtl/instr_fetch_queue.sv | 115 +++++++++++
 tb/tb_instr_fetch_queue.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: address/instruction words,
// fetch FSM states and the packed FIFO entry.
package instr_fetch_queue_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_WAIT    = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        instr_t instr;
        addr_t  pc;
    } fetch_entry_t;

    localparam int    ENTRY_WIDTH = $bits(fetch_entry_t);
    localparam addr_t INSTR_BYTES = 32'd4;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bundles the memory-controller fetch handshake and the decoder-facing head
// port; master is the fetch queue, slave is the memory/decoder side.
interface instr_fetch_queue_if;
    import instr_fetch_queue_pkg::*;

    logic   mem_req;
    addr_t  mem_addr;
    logic   mem_ack;
    instr_t mem_data;

    logic   decode_ready;
    logic   decode_enable;
    instr_t instr;
    addr_t  instr_pc;

    modport master (
        output mem_req, mem_addr, decode_enable, instr, instr_pc,
        input  mem_ack, mem_data, decode_ready
    );

    modport slave (
        input  mem_req, mem_addr, decode_enable, instr, instr_pc,
        output mem_ack, mem_data, decode_ready
    );

endinterface

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Synchronous FIFO with clear; head data and count come straight from flops.
// Storage is reset so the head word reads zero out of reset.
module instr_fetch_queue_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] push_data,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers are exactly PTR_W wide, so increments wrap modulo DEPTH.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[head_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetcher: one outstanding memory request at a time,
// results buffered with their PCs and presented to the decoder in order.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int    DEPTH    = 16,
    parameter addr_t RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       update_stat,
    input  addr_t                      new_pc,
    instr_fetch_queue_if.master        bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    addr_t            pc_q, pc_d;
    addr_t            mem_addr_q, mem_addr_d;
    logic             mem_req_q, mem_req_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after_pop;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;
    logic             push, pop, clear, slot_free;

    assign pop             = rdy && (count != '0) && bus.decode_ready && !update_stat;
    assign clear           = rdy && update_stat;
    assign count_after_pop = count - {{(CNT_W-1){1'b0}}, pop};
    assign slot_free       = count_after_pop < CNT_W'(DEPTH);
    assign push_entry      = '{instr: bus.mem_data, pc: mem_addr_q};

    // A request is only issued when a slot is free, so the ack can always push.
    // A redirect while waiting keeps the request up and drops its data later.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;
        if (rdy) begin
            if (update_stat) begin
                pc_d = new_pc;
            end
            case (state_q)
                FETCH_IDLE: begin
                    if (!update_stat && slot_free) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                        state_d    = FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (bus.mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = FETCH_IDLE;
                        if (!update_stat) begin
                            push = 1'b1;
                            pc_d = pc_q + INSTR_BYTES;
                        end
                    end else if (update_stat) begin
                        state_d = FETCH_DISCARD;
                    end
                end
                FETCH_DISCARD: begin
                    if (bus.mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = FETCH_IDLE;
                    end
                end
                default: begin
                    mem_req_d = 1'b0;
                    state_d   = FETCH_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    instr_fetch_queue_sync_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .push_data (push_entry),
        .count     (count),
        .head_data (head)
    );

    assign bus.mem_req       = mem_req_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.decode_enable = (count != '0);
    assign bus.instr         = head.instr;
    assign bus.instr_pc      = head.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus a random
// run against a queue-based reference model of fetch, buffer and redirect.
module tb_instr_fetch_queue;

    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        update_stat;
    logic [31:0] new_pc;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .update_stat (update_stat),
        .new_pc      (new_pc),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int failures  = 0;
    int ack_wait  = 0;

    // Reference model: a plain queue of buffered instructions, the next fetch
    // PC, and whether a request is outstanding and whether its data is stale.
    entry_t      m_q [$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    bit          m_busy;
    bit          m_stale;

    task automatic model_step();
        bit     do_pop;
        entry_t e;
        if (rst) begin
            m_q.delete();
            m_pc    = 32'h0;
            m_addr  = 32'h0;
            m_busy  = 1'b0;
            m_stale = 1'b0;
        end else if (rdy) begin
            do_pop = (m_q.size() != 0) && bus.decode_ready && !update_stat;
            if (update_stat) begin
                m_q.delete();
                m_pc = new_pc;
                if (m_busy) begin
                    if (bus.mem_ack) begin
                        m_busy  = 1'b0;
                        m_stale = 1'b0;
                    end else begin
                        m_stale = 1'b1;
                    end
                end
            end else begin
                if (do_pop) void'(m_q.pop_front());
                if (m_busy) begin
                    if (bus.mem_ack) begin
                        if (!m_stale) begin
                            e.instr = bus.mem_data;
                            e.pc    = m_addr;
                            m_q.push_back(e);
                            m_pc = m_pc + 32'd4;
                        end
                        m_busy  = 1'b0;
                        m_stale = 1'b0;
                    end
                end else if (m_q.size() < DEPTH) begin
                    m_busy = 1'b1;
                    m_addr = m_pc;
                end
            end
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next one.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Memory controller: acks a held request after a random wait.
    task automatic respond(input int max_delay);
        if (bus.mem_req) begin
            if (ack_wait == 0) begin
                bus.mem_ack  = 1'b1;
                bus.mem_data = $urandom;
                ack_wait     = $urandom_range(max_delay, 0);
            end else begin
                bus.mem_ack = 1'b0;
                ack_wait--;
            end
        end else begin
            bus.mem_ack = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst              = 1'b1;
        rdy              = 1'b1;
        update_stat      = 1'b0;
        new_pc           = 32'h0;
        bus.mem_ack      = 1'b0;
        bus.mem_data     = 32'h0;
        bus.decode_ready = 1'b0;
        ack_wait         = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++; if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
        tests_run++; if (bus.mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
        tests_run++; if (bus.decode_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_decode_enable: got %b expected 0", bus.decode_enable); end
        tests_run++; if (bus.instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr: got %h expected 0", bus.instr); end
        tests_run++; if (bus.instr_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr_pc: got %h expected 0", bus.instr_pc); end
        tick();
        tests_run++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL first_req: got req=%b addr=%h expected req=1 addr=0", bus.mem_req, bus.mem_addr); end
        rst = 1'b1;
        bus.mem_ack  = 1'b1;
        bus.mem_data = 32'hCAFE_F00D;
        tick();
        tests_run++; if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_fetch_req: got %b expected 0", bus.mem_req); end
        rst = 1'b0;
        tick();
        bus.mem_ack = 1'b0;
        tests_run++; if (bus.decode_enable !== 1'b0) begin failures++; $display("[TB] FAIL late_ack_ignored: got decode_enable=%b expected 0", bus.decode_enable); end
    endtask

    task automatic test_sequential();
        logic [31:0] sent [3];
        int n_req = 0;
        int n_pop = 0;
        apply_reset();
        bus.decode_ready = 1'b1;
        for (int c = 0; c < 40 && n_pop < 3; c++) begin
            respond(0);
            if (bus.mem_ack && n_req < 3) begin
                tests_run++;
                if (bus.mem_addr !== 32'(n_req * 4)) begin failures++; $display("[TB] FAIL seq_addr: got %h expected %h", bus.mem_addr, 32'(n_req * 4)); end
                sent[n_req] = bus.mem_data;
                n_req++;
            end
            if (bus.decode_enable) begin
                tests_run++;
                if (bus.instr_pc !== 32'(n_pop * 4) || bus.instr !== sent[n_pop]) begin
                    failures++; $display("[TB] FAIL seq_head: got pc=%h instr=%h expected pc=%h instr=%h", bus.instr_pc, bus.instr, 32'(n_pop * 4), sent[n_pop]);
                end
                n_pop++;
            end
            tick();
        end
        tests_run++; if (n_pop != 3) begin failures++; $display("[TB] FAIL seq_timeout: got %0d pops expected 3", n_pop); end
    endtask

    task automatic test_fill();
        int acks = 0;
        apply_reset();
        for (int c = 0; c < 60; c++) begin
            respond(0);
            if (bus.mem_ack) acks++;
            tick();
        end
        bus.mem_ack = 1'b0;
        tests_run++; if (acks != DEPTH) begin failures++; $display("[TB] FAIL fill_fetches: got %0d expected %0d", acks, DEPTH); end
        tests_run++; if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL fill_req_stops: got %b expected 0", bus.mem_req); end
        tests_run++; if (bus.decode_enable !== 1'b1 || bus.instr_pc !== 32'h0) begin failures++; $display("[TB] FAIL fill_head: got en=%b pc=%h expected en=1 pc=0", bus.decode_enable, bus.instr_pc); end
        bus.decode_ready = 1'b1;
        tick();
        bus.decode_ready = 1'b0;
        tests_run++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40) begin failures++; $display("[TB] FAIL fill_refetch: got req=%b addr=%h expected req=1 addr=40", bus.mem_req, bus.mem_addr); end
        tests_run++; if (bus.instr_pc !== 32'h4) begin failures++; $display("[TB] FAIL fill_pop: got pc=%h expected 4", bus.instr_pc); end
    endtask

    task automatic test_flush_wait();
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            respond(0);
            tick();
        end
        bus.mem_ack = 1'b0;
        tick();
        tests_run++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8) begin failures++; $display("[TB] FAIL flushw_setup: got req=%b addr=%h expected req=1 addr=8", bus.mem_req, bus.mem_addr); end
        update_stat = 1'b1;
        new_pc      = 32'h100;
        tick();
        update_stat = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tests_run++; if (bus.decode_enable !== 1'b0 || bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL flushw_discard: got en=%b req=%b expected en=0 req=1", bus.decode_enable, bus.mem_req); end
            tick();
        end
        bus.mem_ack  = 1'b1;
        bus.mem_data = 32'hBAD0_BAD0;
        tick();
        bus.mem_ack = 1'b0;
        tests_run++; if (bus.mem_req !== 1'b0 || bus.decode_enable !== 1'b0) begin failures++; $display("[TB] FAIL flushw_drop: got req=%b en=%b expected req=0 en=0", bus.mem_req, bus.decode_enable); end
        tick();
        tests_run++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin failures++; $display("[TB] FAIL flushw_newpc: got req=%b addr=%h expected req=1 addr=100", bus.mem_req, bus.mem_addr); end
        bus.mem_ack  = 1'b1;
        bus.mem_data = 32'h1357_9BDF;
        tick();
        bus.mem_ack = 1'b0;
        tests_run++; if (bus.decode_enable !== 1'b1 || bus.instr_pc !== 32'h100 || bus.instr !== 32'h1357_9BDF) begin
            failures++; $display("[TB] FAIL flushw_push: got en=%b pc=%h instr=%h expected en=1 pc=100 instr=13579bdf", bus.decode_enable, bus.instr_pc, bus.instr);
        end
    endtask

    task automatic test_flush_ack();
        logic [31:0] np;
        np = $urandom;
        apply_reset();
        tick();
        update_stat  = 1'b1;
        new_pc       = np;
        bus.mem_ack  = 1'b1;
        bus.mem_data = 32'hDEAD_BEEF;
        tick();
        update_stat = 1'b0;
        bus.mem_ack = 1'b0;
        tests_run++; if (bus.mem_req !== 1'b0 || bus.decode_enable !== 1'b0) begin failures++; $display("[TB] FAIL flusha_drop: got req=%b en=%b expected req=0 en=0", bus.mem_req, bus.decode_enable); end
        tick();
        tests_run++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== np) begin failures++; $display("[TB] FAIL flusha_req: got req=%b addr=%h expected req=1 addr=%h", bus.mem_req, bus.mem_addr, np); end
        bus.mem_ack  = 1'b1;
        bus.mem_data = 32'h2468_ACE0;
        tick();
        bus.mem_ack = 1'b0;
        tests_run++; if (bus.decode_enable !== 1'b1 || bus.instr_pc !== np || bus.instr !== 32'h2468_ACE0) begin
            failures++; $display("[TB] FAIL flusha_push: got en=%b pc=%h instr=%h expected en=1 pc=%h instr=2468ace0", bus.decode_enable, bus.instr_pc, bus.instr, np);
        end
    endtask

    task automatic test_rdy_stall();
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            respond(0);
            tick();
        end
        bus.mem_ack = 1'b0;
        tick();
        rdy              = 1'b0;
        bus.decode_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.mem_ack  = 1'b1;
            bus.mem_data = $urandom;
            tick();
            tests_run++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8 || bus.instr_pc !== 32'h0 || bus.decode_enable !== 1'b1) begin
                failures++; $display("[TB] FAIL stall_hold: got req=%b addr=%h pc=%h en=%b expected req=1 addr=8 pc=0 en=1", bus.mem_req, bus.mem_addr, bus.instr_pc, bus.decode_enable);
            end
        end
        rdy              = 1'b1;
        bus.mem_ack      = 1'b0;
        bus.decode_ready = 1'b0;
        tick();
        tests_run++; if (bus.mem_req !== 1'b1 || bus.instr_pc !== 32'h0) begin failures++; $display("[TB] FAIL stall_ack_ignored: got req=%b pc=%h expected req=1 pc=0", bus.mem_req, bus.instr_pc); end
        bus.mem_ack  = 1'b1;
        bus.mem_data = 32'h0F0F_A5A5;
        tick();
        bus.mem_ack      = 1'b0;
        bus.decode_ready = 1'b1;
        tick();
        tick();
        bus.decode_ready = 1'b0;
        tests_run++; if (bus.instr_pc !== 32'h8 || bus.instr !== 32'h0F0F_A5A5) begin failures++; $display("[TB] FAIL stall_resume: got pc=%h instr=%h expected pc=8 instr=0f0fa5a5", bus.instr_pc, bus.instr); end
    endtask

    task automatic test_back_to_back();
        int          pushes = 0;
        logic [31:0] last_data;
        apply_reset();
        tick();
        bus.mem_ack  = 1'b1;
        bus.mem_data = 32'h1234_5678;
        last_data    = 32'h1234_5678;
        tick();
        bus.mem_ack = 1'b0;
        for (int c = 0; c < 80; c++) begin
            respond(0);
            bus.decode_ready = bus.mem_ack;
            if (bus.mem_ack) begin
                pushes++;
                last_data = bus.mem_data;
            end
            tick();
            tests_run++; if (bus.decode_enable !== 1'b1 || bus.instr_pc !== 32'(pushes * 4) || bus.instr !== last_data) begin
                failures++; $display("[TB] FAIL b2b_head: got en=%b pc=%h instr=%h expected en=1 pc=%h instr=%h", bus.decode_enable, bus.instr_pc, bus.instr, 32'(pushes * 4), last_data);
            end
        end
        bus.decode_ready = 1'b0;
        tests_run++; if (pushes <= DEPTH) begin failures++; $display("[TB] FAIL b2b_wrap: got %0d pushes expected more than %0d", pushes, DEPTH); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            rst              = ($urandom_range(199, 0) == 0);
            rdy              = ($urandom_range(9, 0) != 0);
            bus.decode_ready = $urandom_range(1, 0) == 1;
            update_stat      = ($urandom_range(24, 0) == 0);
            new_pc           = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : $urandom;
            respond(3);
            tick();
            tests_run++; if (bus.mem_req !== m_busy) begin failures++; $display("[TB] FAIL rnd_mem_req: cycle %0d got %b expected %b", c, bus.mem_req, m_busy); end
            tests_run++; if (bus.mem_addr !== m_addr) begin failures++; $display("[TB] FAIL rnd_mem_addr: cycle %0d got %h expected %h", c, bus.mem_addr, m_addr); end
            tests_run++; if (bus.decode_enable !== (m_q.size() != 0)) begin failures++; $display("[TB] FAIL rnd_decode_enable: cycle %0d got %b expected %b", c, bus.decode_enable, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                tests_run++;
                if (bus.instr !== m_q[0].instr || bus.instr_pc !== m_q[0].pc) begin
                    failures++; $display("[TB] FAIL rnd_head: cycle %0d got pc=%h instr=%h expected pc=%h instr=%h", c, bus.instr_pc, bus.instr, m_q[0].pc, m_q[0].instr);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_fill();
        test_flush_wait();
        test_flush_ack();
        test_rdy_stall();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
